// File: rtl/product_accum_pkg.sv
// rtl/product_accum_pkg.sv - shared state encoding and accumulator width for product_accum
package product_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = 5;

    // Four guard bits above the product width absorb sixteen maximal products.
    function automatic int sum_w(input int op_bits);
        return 2 * op_bits + 4;
    endfunction

endpackage

// File: rtl/product_accum_beat_counter.sv
// rtl/product_accum_beat_counter.sv - loadable down-counter of products still expected in a run
module beat_counter
    import product_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - 5'd1;
        end
    end

    assign count_o = r_count;
    assign zero_o  = (r_count == '0);
    assign one_o   = (r_count == 5'd1);

endmodule

// File: rtl/product_accum.sv
// rtl/product_accum.sv - accumulates a run of 1..16 multiplier products into a held sum
module product_accum
    import product_accum_pkg::*;
#(
    parameter  int bits  = 4,
    localparam int SUM_W = sum_w(bits)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        len_i,
    input  logic [2*bits-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic [4:0]        remain_o
);

    state_t           r_state;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_sum;
    logic             r_done;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_beat;
    logic             w_zero;
    logic             w_one;
    logic [SUM_W-1:0] w_prod_ext;
    logic [SUM_W-1:0] w_next_acc;

    assign w_load     = (r_state == IDLE) && start_i;
    assign w_load_val = (len_i == 4'd0) ? 5'd16 : {1'b0, len_i};
    assign w_beat     = (r_state == ACCUM) && prod_valid_i && !w_zero;
    assign w_prod_ext = {{(SUM_W - 2 * bits){1'b0}}, prod_i};
    assign w_next_acc = r_acc + w_prod_ext;

    beat_counter u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .dec_i      (w_beat),
        .count_o    (remain_o),
        .zero_o     (w_zero),
        .one_o      (w_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_acc   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_next_acc;
                        // The final beat publishes the sum on the same edge it is accepted.
                        if (w_one) begin
                            r_sum   <= w_next_acc;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = r_done;
    assign sum_o  = r_sum;

endmodule

// File: tb/tb_product_accum.sv
// tb/tb_product_accum.sv - self-checking bench for product_accum
module tb_product_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  len_i;
    logic [7:0]  prod_i;
    logic        prod_valid_i;
    logic        busy_o;
    logic        done_o;
    logic [11:0] sum_o;
    logic [4:0]  remain_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] len;
        logic       valid;
        logic [7:0] prod;
        logic       e_busy;
        logic       e_done;
        int         e_rem;
        int         e_sum;
    } vec_t;

    vec_t       vt[9];
    logic [7:0] q_prod[$];

    product_accum #(.bits(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .len_i        (len_i),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sum_o        (sum_o),
        .remain_o     (remain_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int e_busy, input int e_done,
                            input int e_rem, input int e_sum);
        chk({name, "_busy"}, int'(busy_o), e_busy);
        chk({name, "_done"}, int'(done_o), e_done);
        chk({name, "_rem"},  int'(remain_o), e_rem);
        chk({name, "_sum"},  int'(sum_o), e_sum);
    endtask

    // Drive one run from q_prod with random stalls; the expected sum is the plain
    // arithmetic total of the queued products and remain is length minus beats taken.
    task automatic run_q(input logic [3:0] len, input int max_gap, input int prev_sum);
        int n;
        int acc;
        int gap;
        n   = (len == 4'd0) ? 16 : int'(len);
        acc = 0;
        start_i = 1'b1; len_i = len; prod_valid_i = 1'b0; prod_i = 8'($urandom);
        tick();
        chk("run_start_rem", int'(remain_o), n);
        chk("run_start_busy", int'(busy_o), 1);
        for (int k = 0; k < n; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                prod_valid_i = 1'b0; prod_i = 8'($urandom);
                start_i = 1'($urandom); len_i = 4'($urandom);
                tick();
                chk("stall_rem", int'(remain_o), n - k);
                chk("stall_done", int'(done_o), 0);
            end
            prod_valid_i = 1'b1; prod_i = q_prod[k];
            start_i = 1'($urandom); len_i = 4'($urandom);
            tick();
            acc += int'(q_prod[k]);
            chk("beat_rem", int'(remain_o), n - k - 1);
            chk("beat_done", int'(done_o), (k == n - 1) ? 1 : 0);
            chk("beat_sum", int'(sum_o), (k == n - 1) ? (acc % 4096) : prev_sum);
        end
        prod_valid_i = 1'b0; start_i = 1'b0;
        tick();
        chk_outs("run_end", 0, 0, 0, acc % 4096);
    endtask

    initial begin
        int last_sum;
        int n;

        //           rst   st    len   vld   prod     busy  done  rem  sum
        vt[0] = '{1'b0, 1'b1, 4'd3, 1'b1, 8'd99,  1'b1, 1'b0, 3, 0};
        vt[1] = '{1'b0, 1'b0, 4'd0, 1'b1, 8'd15,  1'b1, 1'b0, 2, 0};
        vt[2] = '{1'b0, 1'b1, 4'd7, 1'b1, 8'd30,  1'b1, 1'b0, 1, 0};
        vt[3] = '{1'b0, 1'b0, 4'd0, 1'b1, 8'd225, 1'b1, 1'b1, 0, 270};
        vt[4] = '{1'b0, 1'b1, 4'd5, 1'b1, 8'd7,   1'b0, 1'b0, 0, 270};
        vt[5] = '{1'b0, 1'b0, 4'd0, 1'b1, 8'd50,  1'b0, 1'b0, 0, 270};
        vt[6] = '{1'b0, 1'b1, 4'd1, 1'b0, 8'd0,   1'b1, 1'b0, 1, 270};
        vt[7] = '{1'b0, 1'b1, 4'd9, 1'b1, 8'd1,   1'b1, 1'b1, 0, 1};
        vt[8] = '{1'b0, 1'b1, 4'd4, 1'b0, 8'd0,   1'b0, 1'b0, 0, 1};

        rst = 1'b1; start_i = 1'b0; len_i = 4'd0; prod_i = 8'd0; prod_valid_i = 1'b0;
        tick();
        tick();
        chk_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_outs("idle", 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            rst = vt[i].rst; start_i = vt[i].start; len_i = vt[i].len;
            prod_valid_i = vt[i].valid; prod_i = vt[i].prod;
            tick();
            chk_outs($sformatf("vec%0d", i), int'(vt[i].e_busy), int'(vt[i].e_done),
                     vt[i].e_rem, vt[i].e_sum);
        end

        // Reset mid-run with remain=3, then confirm no late done pulse.
        start_i = 1'b1; len_i = 4'd5; prod_valid_i = 1'b0;
        tick();
        start_i = 1'b0; prod_valid_i = 1'b1; prod_i = 8'd40;
        tick();
        tick();
        chk("pre_rst_rem", int'(remain_o), 3);
        rst = 1'b1; start_i = 1'b1;
        tick();
        chk_outs("midrst1", 0, 0, 0, 0);
        tick();
        chk_outs("midrst2", 0, 0, 0, 0);
        rst = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_outs("post_rst", 0, 0, 0, 0);
        end
        prod_valid_i = 1'b0;

        // Maximum run: sixteen beats of 15*15.
        q_prod.delete();
        for (int i = 0; i < 16; i++) q_prod.push_back(8'd225);
        run_q(4'd0, 0, 0);
        chk("max_sum", int'(sum_o), 3600);

        // Valid beats while idle must not leak into the next run.
        prod_valid_i = 1'b1; prod_i = 8'd100;
        repeat (3) tick();
        chk_outs("idle_beats", 0, 0, 0, 3600);
        q_prod.delete();
        q_prod.push_back(8'd6);
        q_prod.push_back(8'd9);
        start_i = 1'b1; len_i = 4'd2; prod_valid_i = 1'b1; prod_i = 8'd100;
        tick();
        start_i = 1'b0; prod_i = q_prod[0];
        tick();
        chk("stall_b1_rem", int'(remain_o), 1);
        prod_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            prod_i = 8'd200;
            tick();
            chk_outs("stall_gap", 1, 0, 1, 3600);
        end
        prod_valid_i = 1'b1; prod_i = q_prod[1];
        tick();
        chk_outs("stall_last", 1, 1, 0, 15);
        prod_valid_i = 1'b0;
        tick();
        chk_outs("stall_after", 0, 0, 0, 15);

        // All A*B products, one full-length run per A.
        last_sum = 15;
        for (int a = 0; a < 16; a++) begin
            q_prod.delete();
            for (int b = 0; b < 16; b++) q_prod.push_back(8'(a * b));
            run_q(4'd0, 0, last_sum);
            chk("exh_sum", int'(sum_o), a * 120);
            last_sum = a * 120;
        end

        // Random runs with random lengths, products and stalls.
        for (int r = 0; r < 25; r++) begin
            logic [3:0] l;
            l = 4'($urandom);
            n = (l == 4'd0) ? 16 : int'(l);
            q_prod.delete();
            for (int k = 0; k < n; k++) q_prod.push_back(8'($urandom));
            run_q(l, 3, last_sum);
            last_sum = int'(sum_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/product_accum.md
PRODUCT_ACCUM -- requirements
Module: product_accum

Interface
REQ-001 Parameter: bits, 4, operand width of the upstream multiplier; product width is 2*bits.
REQ-002 Derived constant: SUM_W = 2*bits+4, accumulator width; holds 16 maximal products without overflow.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  begin a new accumulation run; sampled only in IDLE.
REQ-006 len_i  input  4  number of products in the run; 0 encodes 16; sampled with start_i.
REQ-007 prod_i  input  2*bits  unsigned product from the multiplier (Product_o).
REQ-008 prod_valid_i  input  1  prod_i is valid this cycle.
REQ-009 busy_o  output  1  high while in ACCUM or DONE.
REQ-010 done_o  output  1  one-cycle pulse when sum_o receives a new result.
REQ-011 sum_o  output  SUM_W  last completed sum; held until the next run completes.
REQ-012 remain_o  output  5  products still expected in the current run (0..16).

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-014 IDLE: start_i=1 -> load remain = (len_i==0 ? 16 : len_i), clear internal acc to 0, go ACCUM next cycle.
REQ-015 IDLE: prod_valid_i SHALL be ignored; acc and sum_o unchanged.
REQ-016 ACCUM: each cycle with prod_valid_i=1 -> acc <= acc + zero-extended prod_i, remain <= remain-1.
REQ-017 ACCUM: prod_valid_i=0 -> acc and remain hold; no timeout.
REQ-018 ACCUM: valid beat accepted while remain==1 -> next state DONE, sum_o <= acc + prod_i on the same edge.
REQ-019 DONE: done_o=1 for exactly this one cycle; unconditional transition to IDLE next cycle.
REQ-020 DONE: prod_valid_i and start_i SHALL be ignored.
REQ-021 start_i in ACCUM or DONE SHALL be ignored; an in-progress run is never restarted.
REQ-022 Latency: done_o and new sum_o visible the cycle after the edge that accepts the last valid beat.
REQ-023 Arithmetic unsigned, modulo 2^SUM_W; overflow cannot occur for legal inputs and needs no flag.
REQ-024 Back-to-back: start_i asserted in the IDLE cycle right after DONE SHALL start a new run; minimum run period is len+2 cycles.
REQ-025 busy_o = (state != IDLE), combinational from state register.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, acc=0, remain_o=0, sum_o=0, done_o=0, busy_o=0, regardless of state.
REQ-027 Reset mid-run SHALL discard partial acc; no done_o pulse is produced for the aborted run.
REQ-028 rst has priority over start_i and prod_valid_i in the same cycle.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE, ACCUM, DONE) and SUM_W derivation.
REQ-030 One sub-module is natural: beat_counter (5-bit loadable down-counter with load, dec, zero/one flags); all else in product_accum.
REQ-031 All outputs SHALL be registered except busy_o (decoded from state register).

Verification
REQ-032 Reset: rst=1 two cycles mid-ACCUM (remain=3) -> state IDLE, sum_o=0, remain_o=0, no done_o pulse.
REQ-033 Short run: start_i, len_i=3, products 15,30,225 on consecutive valid cycles -> done_o one cycle after third beat, sum_o=270.
REQ-034 Max run: len_i=0, sixteen beats of 225 (15*15) -> sum_o=3600, remain_o counts 16..0, single done_o.
REQ-035 Stalls: len_i=2, products 6 and 9 separated by 5 invalid cycles -> sum_o=15, done_o only after beat 2; valid beats while IDLE before start_i do not affect sum.
REQ-036 Ignored start: start_i re-asserted during ACCUM and DONE -> run unaffected; start_i in IDLE after DONE with len_i=1, product 1 -> sum_o=1.
REQ-037 Exhaustive: drive all 256 A,B pairs through multi_4bits into len_i=0 runs (16 per run, A fixed) -> each sum_o = A*120.
